// File: rtl/alu_fun_decode_stage.sv
// ID/EX boundary: decodes the ID instruction into the ALU control word and registers it into EX.
// Also flags undecodable instructions and keeps a saturating count of them.
module alu_fun_decode_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [5:0]       ex_ALUFun,
    output logic             ex_Sign,
    output logic [1:0]       ex_ALUSrc1,
    output logic             ex_ALUSrc2,
    output logic             ex_ImmZero,
    output logic             ex_valid,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [5:0] dec_fun;
    logic       dec_sign;
    logic [1:0] dec_src1;
    logic       dec_src2;
    logic       dec_immz;
    logic       dec_legal;

    assign op    = id_instr[31:26];
    assign rt    = id_instr[20:16];
    assign funct = id_instr[5:0];

    // Every legal instruction is signed unless it is one of the explicit unsigned variants.
    always_comb begin
        dec_fun   = 6'b000000;
        dec_sign  = 1'b1;
        dec_src1  = 2'b00;
        dec_src2  = 1'b0;
        dec_immz  = 1'b0;
        dec_legal = 1'b1;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20: dec_fun = 6'b000000;
                    6'h21: begin dec_fun = 6'b000000; dec_sign = 1'b0; end
                    6'h22: dec_fun = 6'b000001;
                    6'h23: begin dec_fun = 6'b000001; dec_sign = 1'b0; end
                    6'h24: dec_fun = 6'b011000;
                    6'h25: dec_fun = 6'b011110;
                    6'h26: dec_fun = 6'b010110;
                    6'h27: dec_fun = 6'b010001;
                    6'h2A: dec_fun = 6'b110101;
                    6'h2B: begin dec_fun = 6'b110101; dec_sign = 1'b0; end
                    6'h00: begin dec_fun = 6'b100000; dec_src1 = 2'b01; end
                    6'h02: begin dec_fun = 6'b100001; dec_src1 = 2'b01; end
                    6'h03: begin dec_fun = 6'b100011; dec_src1 = 2'b01; end
                    6'h08, 6'h09: dec_fun = 6'b000000;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin dec_fun = 6'b000000; dec_src2 = 1'b1; end
            6'h09: begin dec_fun = 6'b000000; dec_src2 = 1'b1; dec_sign = 1'b0; end
            6'h0A: begin dec_fun = 6'b110101; dec_src2 = 1'b1; end
            6'h0B: begin dec_fun = 6'b110101; dec_src2 = 1'b1; dec_sign = 1'b0; end
            6'h0C: begin dec_fun = 6'b011000; dec_src2 = 1'b1; dec_immz = 1'b1; end
            6'h0D: begin dec_fun = 6'b011110; dec_src2 = 1'b1; dec_immz = 1'b1; end
            6'h0E: begin dec_fun = 6'b010110; dec_src2 = 1'b1; dec_immz = 1'b1; end
            6'h0F: begin dec_fun = 6'b100000; dec_src2 = 1'b1; dec_src1 = 2'b10; end
            6'h23, 6'h2B: begin dec_fun = 6'b000000; dec_src2 = 1'b1; end
            6'h04: dec_fun = 6'b110011;
            6'h05: dec_fun = 6'b110001;
            6'h06: dec_fun = 6'b111101;
            6'h07: dec_fun = 6'b111111;
            6'h01: begin
                if (rt == 5'd0) dec_fun = 6'b111011;
                else            dec_legal = 1'b0;
            end
            6'h02, 6'h03: dec_fun = 6'b000000;
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_fun  = 6'b000000;
            dec_sign = 1'b0;
            dec_src1 = 2'b00;
            dec_src2 = 1'b0;
            dec_immz = 1'b0;
        end
    end

    // Priority per edge: reset > flush > stall > load; a bubble is the reset word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ALUFun   <= '0;
            ex_Sign     <= 1'b0;
            ex_ALUSrc1  <= '0;
            ex_ALUSrc2  <= 1'b0;
            ex_ImmZero  <= 1'b0;
            ex_valid    <= 1'b0;
            ex_illegal  <= 1'b0;
            illegal_cnt <= '0;
        end else if (flush || (!stall && !id_valid)) begin
            ex_ALUFun  <= '0;
            ex_Sign    <= 1'b0;
            ex_ALUSrc1 <= '0;
            ex_ALUSrc2 <= 1'b0;
            ex_ImmZero <= 1'b0;
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (!stall) begin
            ex_ALUFun  <= dec_fun;
            ex_Sign    <= dec_sign;
            ex_ALUSrc1 <= dec_src1;
            ex_ALUSrc2 <= dec_src2;
            ex_ImmZero <= dec_immz;
            ex_valid   <= dec_legal;
            ex_illegal <= !dec_legal;
            if (!dec_legal && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_fun_decode_stage.sv
// Directed and randomized bench for alu_fun_decode_stage against a table-driven decode model.
module tb_alu_fun_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        stall;
    logic        flush;
    logic [5:0]  ex_ALUFun;
    logic        ex_Sign;
    logic [1:0]  ex_ALUSrc1;
    logic        ex_ALUSrc2;
    logic        ex_ImmZero;
    logic        ex_valid;
    logic        ex_illegal;
    logic [7:0]  illegal_cnt;

    alu_fun_decode_stage #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
        .stall(stall), .flush(flush), .ex_ALUFun(ex_ALUFun), .ex_Sign(ex_Sign),
        .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2), .ex_ImmZero(ex_ImmZero),
        .ex_valid(ex_valid), .ex_illegal(ex_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         r;
        logic [5:0] code;
        logic [5:0] fun;
        bit         sign;
        logic [1:0] s1;
        bit         s2;
        bit         iz;
    } ent_t;

    ent_t tbl[$];

    int tests = 0;
    int fails = 0;

    logic [5:0] e_fun;
    logic       e_sign, e_s2, e_iz, e_valid, e_ill;
    logic [1:0] e_s1;
    int         e_cnt;

    function automatic void add(bit r, logic [5:0] code, logic [5:0] fun, bit sign,
                                logic [1:0] s1, bit s2, bit iz);
        ent_t e;
        e.r = r; e.code = code; e.fun = fun; e.sign = sign; e.s1 = s1; e.s2 = s2; e.iz = iz;
        tbl.push_back(e);
    endfunction

    function automatic void build_table();
        add(1, 6'h20, 6'b000000, 1, 0, 0, 0);
        add(1, 6'h21, 6'b000000, 0, 0, 0, 0);
        add(1, 6'h22, 6'b000001, 1, 0, 0, 0);
        add(1, 6'h23, 6'b000001, 0, 0, 0, 0);
        add(1, 6'h24, 6'b011000, 1, 0, 0, 0);
        add(1, 6'h25, 6'b011110, 1, 0, 0, 0);
        add(1, 6'h26, 6'b010110, 1, 0, 0, 0);
        add(1, 6'h27, 6'b010001, 1, 0, 0, 0);
        add(1, 6'h2A, 6'b110101, 1, 0, 0, 0);
        add(1, 6'h2B, 6'b110101, 0, 0, 0, 0);
        add(1, 6'h00, 6'b100000, 1, 1, 0, 0);
        add(1, 6'h02, 6'b100001, 1, 1, 0, 0);
        add(1, 6'h03, 6'b100011, 1, 1, 0, 0);
        add(1, 6'h08, 6'b000000, 1, 0, 0, 0);
        add(1, 6'h09, 6'b000000, 1, 0, 0, 0);
        add(0, 6'h08, 6'b000000, 1, 0, 1, 0);
        add(0, 6'h09, 6'b000000, 0, 0, 1, 0);
        add(0, 6'h0A, 6'b110101, 1, 0, 1, 0);
        add(0, 6'h0B, 6'b110101, 0, 0, 1, 0);
        add(0, 6'h0C, 6'b011000, 1, 0, 1, 1);
        add(0, 6'h0D, 6'b011110, 1, 0, 1, 1);
        add(0, 6'h0E, 6'b010110, 1, 0, 1, 1);
        add(0, 6'h0F, 6'b100000, 1, 2, 1, 0);
        add(0, 6'h23, 6'b000000, 1, 0, 1, 0);
        add(0, 6'h2B, 6'b000000, 1, 0, 1, 0);
        add(0, 6'h04, 6'b110011, 1, 0, 0, 0);
        add(0, 6'h05, 6'b110001, 1, 0, 0, 0);
        add(0, 6'h06, 6'b111101, 1, 0, 0, 0);
        add(0, 6'h07, 6'b111111, 1, 0, 0, 0);
        add(0, 6'h01, 6'b111011, 1, 0, 0, 0);
        add(0, 6'h02, 6'b000000, 1, 0, 0, 0);
        add(0, 6'h03, 6'b000000, 1, 0, 0, 0);
    endfunction

    // Returns the matching table index, or -1 for an undecodable instruction.
    function automatic int lookup(logic [31:0] ins);
        bit         is_r = (ins[31:26] == 6'h00);
        logic [5:0] key  = is_r ? ins[5:0] : ins[31:26];
        if (ins[31:26] == 6'h01 && ins[20:16] != 5'd0) return -1;
        foreach (tbl[i])
            if (tbl[i].r == is_r && tbl[i].code == key) return i;
        return -1;
    endfunction

    function automatic void clear_exp();
        e_fun = 0; e_sign = 0; e_s1 = 0; e_s2 = 0; e_iz = 0; e_valid = 0; e_ill = 0;
    endfunction

    function automatic void model_edge(logic [31:0] ins, logic v, logic st, logic fl);
        int k;
        if (fl || (!st && !v)) begin
            clear_exp();
        end else if (!st) begin
            k = lookup(ins);
            clear_exp();
            if (k < 0) begin
                e_ill = 1;
                if (e_cnt < 255) e_cnt++;
            end else begin
                e_fun = tbl[k].fun; e_sign = tbl[k].sign; e_s1 = tbl[k].s1;
                e_s2 = tbl[k].s2; e_iz = tbl[k].iz; e_valid = 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fun"},     {26'd0, ex_ALUFun},   {26'd0, e_fun});
        chk({tag, ".sign"},    {31'd0, ex_Sign},     {31'd0, e_sign});
        chk({tag, ".src1"},    {30'd0, ex_ALUSrc1},  {30'd0, e_s1});
        chk({tag, ".src2"},    {31'd0, ex_ALUSrc2},  {31'd0, e_s2});
        chk({tag, ".immz"},    {31'd0, ex_ImmZero},  {31'd0, e_iz});
        chk({tag, ".valid"},   {31'd0, ex_valid},    {31'd0, e_valid});
        chk({tag, ".illegal"}, {31'd0, ex_illegal},  {31'd0, e_ill});
        chk({tag, ".cnt"},     {24'd0, illegal_cnt}, e_cnt);
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic v,
                        input logic st, input logic fl);
        @(negedge clk);
        id_instr = ins; id_valid = v; stall = st; flush = fl;
        @(posedge clk);
        model_edge(ins, v, st, fl);
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        int k;
        if ($urandom_range(0, 7) == 0) return ins;
        k = $urandom_range(0, tbl.size() - 1);
        if (tbl[k].r) begin
            ins[31:26] = 6'h00;
            ins[5:0]   = tbl[k].code;
        end else begin
            ins[31:26] = tbl[k].code;
            if (tbl[k].code == 6'h01 && $urandom_range(0, 3) != 0) ins[20:16] = 5'd0;
        end
        return ins;
    endfunction

    initial begin
        build_table();
        reset = 1; id_instr = 0; id_valid = 0; stall = 0; flush = 0;
        clear_exp(); e_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 0;

        step("add",  32'h00851020, 1, 0, 0);
        chk("add.sign_lit", {31'd0, ex_Sign}, 32'd1);
        step("sll",  32'h00041080, 1, 0, 0);
        step("lui",  32'h3C011234, 1, 0, 0);
        step("andi", 32'h3082FFFF, 1, 0, 0);
        step("sltu", 32'h0085102B, 1, 0, 0);
        step("beq",  32'h10850003, 1, 0, 0);
        step("bne",  32'h14850003, 1, 0, 0);
        step("blez", 32'h18800003, 1, 0, 0);
        step("bgtz", 32'h1C800003, 1, 0, 0);
        step("bltz", 32'h04800002, 1, 0, 0);
        step("op1rt1", 32'h04810002, 1, 0, 0);
        step("bubble", 32'h00851020, 0, 0, 0);

        step("hold_ld", 32'h00851020, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("hold_stall", 32'h00851022, 1, 1, 0);
        chk("hold.valid_lit", {31'd0, ex_valid}, 32'd1);
        step("stall_flush", 32'h00851022, 1, 1, 1);
        step("ill_stall", 32'hFC000000, 1, 1, 0);

        for (int i = 0; i < 300; i++)
            step("rand", rand_instr(), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));

        for (int i = 0; i < 260; i++) step("sat", 32'hFC000000, 1, 0, 0);
        chk("sat.lit", {24'd0, illegal_cnt}, 32'd255);
        step("sat_flush", 32'hFC000000, 1, 0, 1);

        step("or", 32'h00851025, 1, 0, 0);
        @(negedge clk);
        #2 reset = 1;
        #1;
        clear_exp(); e_cnt = 0;
        check_all("async_rst");
        @(negedge clk);
        reset = 0;
        step("post_rst_add", 32'h00851020, 1, 0, 0);
        step("post_rst_ill", 32'hFC000000, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_fun_decode_stage.md
Name: alu_fun_decode_stage

Overview:
- ID/EX-boundary producer of the ALU control word: decodes the ID-stage MIPS instruction into ALUFun[5:0], Sign and operand-select controls, then registers them into the EX stage.
- ALUFun[5:4] selects the ALU result group: 00 add/sub, 01 logic, 10 shift, 11 compare.
- Includes stall/flush pipeline-register behaviour, illegal-opcode detection and a saturating illegal-instruction counter.

Parameters:
- CNT_W, 8, width of illegal-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_instr  in  32  ID-stage instruction word.
- id_valid  in  1  id_instr holds a real instruction.
- stall  in  1  hold EX register contents.
- flush  in  1  load a bubble into EX.
- ex_ALUFun  out  6  ALU function code.
- ex_Sign  out  1  1 = signed compare/overflow, 0 = unsigned.
- ex_ALUSrc1  out  2  00 rs, 01 shamt, 10 constant 16.
- ex_ALUSrc2  out  1  0 rt, 1 extended immediate.
- ex_ImmZero  out  1  1 = zero-extend imm16, 0 = sign-extend.
- ex_valid  out  1  EX holds a legal instruction.
- ex_illegal  out  1  EX holds an undecodable instruction.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions loaded.

Behaviour:
- Reset (async):
  - All ex_* outputs = 0 (ALUFun 000000, Sign 0, ALUSrc1 00, ALUSrc2 0, ImmZero 0, valid 0, illegal 0).
  - illegal_cnt = 0.
- Latency: decode is combinational from id_instr; every output is registered, so an instruction presented in cycle N appears on the outputs in cycle N+1.
- Per-edge priority: reset > flush > stall > load.
  - Flush (regardless of stall): load the reset values into all ex_* outputs; illegal_cnt unchanged.
  - Stall without flush: all ex_* outputs and illegal_cnt hold.
  - Load with id_valid=0: bubble, same as flush.
  - Load with id_valid=1: register the decoded fields. ex_valid = legal, ex_illegal = !legal.
- Counter: illegal_cnt increments by 1 on a load of an illegal instruction and saturates at 2^CNT_W-1. No increment under flush or stall.
- Decode, R-type (op=0), by funct; Sign=1 unless noted:
  - 20 add → 000000.
  - 21 addu → 000000, Sign=0.
  - 22 sub → 000001.
  - 23 subu → 000001, Sign=0.
  - 24 and → 011000.
  - 25 or → 011110.
  - 26 xor → 010110.
  - 27 nor → 010001.
  - 2A slt → 110101.
  - 2B sltu → 110101, Sign=0.
  - 00 sll / 02 srl / 03 sra → 100000 / 100001 / 100011, with ALUSrc1=01.
  - 08 jr / 09 jalr → 000000.
  - Any other funct → illegal.
- Decode, I/J-type, by opcode (hex); ALUSrc2=1 for all of these except the branches and jumps:
  - 08 addi → 000000.
  - 09 addiu → 000000, Sign=0.
  - 0A slti → 110101.
  - 0B sltiu → 110101, Sign=0.
  - 0C andi → 011000, ImmZero=1.
  - 0D ori → 011110, ImmZero=1.
  - 0E xori → 010110, ImmZero=1.
  - 0F lui → 100000, ALUSrc1=10.
  - 23 lw / 2B sw → 000000.
  - Branches (ALUSrc2=0): 04 beq → 110011; 05 bne → 110001; 06 blez → 111101; 07 bgtz → 111111.
  - 01 with rt=0 (bltz) → 111011. Op 01 with any other rt → illegal.
  - 02 j / 03 jal → 000000, ALUSrc2=0.
  - Any other opcode → illegal.
- Illegal instruction: ALUFun/Sign/Src/ImmZero forced to 0, ex_valid=0, ex_illegal=1.
- Fields not listed for an instruction default to 0.
- Reset asserted mid-stall or mid-flush forces the reset values immediately; the first load after reset release is honoured normally.

Test Plan:
- Reset, then id_valid=1, id_instr=0x00851020 (add) → next cycle ex_ALUFun=000000, ex_Sign=1, ex_valid=1, ex_ALUSrc1=00, ex_ALUSrc2=0.
- Sequence sll 0x00041080, lui 0x3C011234, andi 0x3082FFFF, sltu 0x0085102B on consecutive cycles → ALUFun 100000/Src1=01; 100000/Src1=10; 011000/ImmZero=1/Src2=1; 110101/Sign=0.
- Branch coverage: beq 0x10850003 → 110011; bne → 110001; blez → 111101; bgtz → 111111; bltz 0x04800002 → 111011; op 01 with rt=1 → ex_illegal=1, ex_valid=0.
- Load add, then stall=1 for 3 cycles while id_instr changes to sub → outputs hold 000000, valid=1 throughout. Then stall=1 with flush=1 → ex_valid=0, ALUFun=000000.
- Apply 260 consecutive illegal instructions (opcode 0x3F), CNT_W=8 → illegal_cnt reaches 255 and stays 255. Illegal instruction with flush=1 → no increment.
- Load or instruction, assert reset asynchronously mid-cycle → outputs clear before the next clk edge. The first instruction after release is decoded with 1-cycle latency.
